debouncer_n: RTL and testbench



---
 rtl/debouncer_n_pkg.sv | 18 +
 rtl/debounce_channel.sv | 83 ++++++++
 rtl/debouncer_n.sv | 69 ++++++
 tb/tb_debouncer_n.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_n_pkg.sv
// rtl/debouncer_n_pkg.sv - shared constants and helpers for the N-channel debouncer
package debouncer_n_pkg;

    localparam int DEB_SYNC_STAGES_DEFAULT  = 2;
    localparam int DEB_STABLE_TICKS_DEFAULT = 4;
    localparam int GLITCH_CNT_W             = 8;

    // PS/2 preset for a 27 MHz system clock
    localparam int PS2_PRESCALE     = 27;
    localparam int PS2_STABLE_TICKS = 4;

    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

    function automatic int counterWidth(input int maxCount);
        return (maxCount <= 1) ? 1 : $clog2(maxCount);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, stability counter, strobes; glitch counter under DEBOUNCER_GLITCH_COUNT_EN
module debounce_channel
    import debouncer_n_pkg::*;
#(
    parameter int SYNC_STAGES  = DEB_SYNC_STAGES_DEFAULT,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
    parameter bit RESET_LEVEL  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    in,
    input  logic                    glitchClear,
    output logic                    out,
    output logic                    rise,
    output logic                    fall,
    output logic [GLITCH_CNT_W-1:0] glitchCount
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] syncQ;
    logic [CNT_W-1:0]       cnt;
    logic                   outQ;
    logic                   s;

    assign s   = syncQ[SYNC_STAGES-1];
    assign out = outQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], in};
        end
    end

    // The counter only advances while s disagrees with out, so it tops out at CNT_LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            outQ <= RESET_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (s == outQ) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    outQ <= s;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef DEBOUNCER_GLITCH_COUNT_EN
    logic [GLITCH_CNT_W-1:0] glitchQ;

    // An aborted transition is a tick where the input fell back while a count was pending.
    always_ff @(posedge clk) begin
        if (reset || glitchClear) begin
            glitchQ <= '0;
        end else if (tick && (s == outQ) && (cnt != '0) && (glitchQ != GLITCH_CNT_MAX)) begin
            glitchQ <= glitchQ + GLITCH_CNT_W'(1);
        end
    end

    assign glitchCount = glitchQ;
`else
    logic unusedGlitchClear;
    assign unusedGlitchClear = glitchClear;
    assign glitchCount       = '0;
`endif

endmodule

// File: rtl/debouncer_n.sv
// rtl/debouncer_n.sv - CHANNELS-wide debouncer with shared prescaler; glitch counters under DEBOUNCER_GLITCH_COUNT_EN
module debouncer_n
    import debouncer_n_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SYNC_STAGES  = DEB_SYNC_STAGES_DEFAULT,
    parameter int PRESCALE     = 1,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
    parameter bit RESET_LEVEL  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          in,
    output logic [CHANNELS-1:0]          out,
    output logic [CHANNELS-1:0]          rise,
    output logic [CHANNELS-1:0]          fall,
    input  logic                         glitchClear,
    output logic [GLITCH_CNT_W*CHANNELS-1:0] glitchCount
);

    if (CHANNELS < 1) begin : gBadChannels
        $error("debouncer_n: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : gBadSyncStages
        $error("debouncer_n: SYNC_STAGES must be >= 2");
    end
    if (PRESCALE < 1) begin : gBadPrescale
        $error("debouncer_n: PRESCALE must be >= 1");
    end
    if (STABLE_TICKS < 1) begin : gBadStableTicks
        $error("debouncer_n: STABLE_TICKS must be >= 1");
    end

    localparam int PS_W = counterWidth(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] psCnt;
    logic            tick;

    // With PRESCALE=1 the counter sits at 0 == PS_LAST, so tick is high every cycle.
    assign tick = (psCnt == PS_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            psCnt <= '0;
        end else begin
            psCnt <= psCnt + PS_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_LEVEL (RESET_LEVEL)
        ) uChannel (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .in         (in[i]),
            .glitchClear(glitchClear),
            .out        (out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .glitchCount(glitchCount[GLITCH_CNT_W*i +: GLITCH_CNT_W])
        );
    end

endmodule

// File: tb/tb_debouncer_n.sv
// tb/tb_debouncer_n.sv - scoreboard bench for debouncer_n at PRESCALE=1 and PRESCALE=27
module tb_debouncer_n;

`ifdef DEBOUNCER_GLITCH_COUNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    typedef struct {
        int lo;
        int hi;
        int ch;
        bit isRise;
        bit dutB;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  inA, outA, riseA, fallA;
    logic [2:0]  inB, outB, riseB, fallB;
    logic        glitchClearA, glitchClearB;
    logic [23:0] glitchCountA, glitchCountB;

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;
    ev_t expQ[$];
    ev_t obsQ[$];

    debouncer_n #(.CHANNELS(3), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(4), .RESET_LEVEL(1'b1)) dutA (
        .clk(clk), .reset(reset), .in(inA), .out(outA), .rise(riseA), .fall(fallA),
        .glitchClear(glitchClearA), .glitchCount(glitchCountA)
    );

    debouncer_n #(.CHANNELS(3), .SYNC_STAGES(2), .PRESCALE(27), .STABLE_TICKS(4), .RESET_LEVEL(1'b1)) dutB (
        .clk(clk), .reset(reset), .in(inB), .out(outB), .rise(riseB), .fall(fallB),
        .glitchClear(glitchClearB), .glitchCount(glitchCountB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe-high cycle becomes one observed event, so wide or doubled strobes show up as extras.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (riseA[i] === 1'b1) obsQ.push_back('{cyc, cyc, i, 1'b1, 1'b0});
            if (fallA[i] === 1'b1) obsQ.push_back('{cyc, cyc, i, 1'b0, 1'b0});
            if (riseB[i] === 1'b1) obsQ.push_back('{cyc, cyc, i, 1'b1, 1'b1});
            if (fallB[i] === 1'b1) obsQ.push_back('{cyc, cyc, i, 1'b0, 1'b1});
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        inA = 3'b000;
        inB = 3'b000;
        glitchClearA = 1'b0;
        glitchClearB = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (outA !== 3'b111 || outB !== 3'b111 || riseA !== 3'b000 || fallA !== 3'b000 ||
            riseB !== 3'b000 || fallB !== 3'b000 || glitchCountA !== 24'd0 || glitchCountB !== 24'd0) begin
            nFails++;
            $display("FAIL reset_during: outA=%b outB=%b riseA=%b fallA=%b riseB=%b fallB=%b gcA=%h gcB=%h, expected out=111 strobes=0 gc=0",
                     outA, outB, riseA, fallA, riseB, fallB, glitchCountA, glitchCountB);
        end
        inA = 3'b111;
        inB = 3'b111;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        nChecks++;
        if (outA !== 3'b111 || outB !== 3'b111 || glitchCountA !== 24'd0 || glitchCountB !== 24'd0) begin
            nFails++;
            $display("FAIL reset_after: outA=%b outB=%b gcA=%h gcB=%h, expected out=111 gc=0", outA, outB, glitchCountA, glitchCountB);
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL reset_strobes: %0d strobes seen, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_latency();
        int n;
        ev_t e, o;
        for (int dir = 0; dir < 2; dir++) begin
            @(negedge clk);
            n = cyc;
            inA[0] = dir[0];
            expQ.push_back('{n + 6, n + 6, 0, dir[0], 1'b0});
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (cyc == n + 5) begin
                    nChecks++;
                    if (outA[0] !== ~dir[0]) begin
                        nFails++;
                        $display("FAIL latency_early: out[0]=%b at cycle +5, expected %b", outA[0], ~dir[0]);
                    end
                end
                if (cyc == n + 6) begin
                    nChecks++;
                    if (outA[0] !== dir[0]) begin
                        nFails++;
                        $display("FAIL latency_on_time: out[0]=%b at cycle +6, expected %b", outA[0], dir[0]);
                    end
                end
            end
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (obsQ.size() == 0) begin
                nFails++;
                $display("FAIL latency_strobe: observed none, expected ch%0d rise=%0d at cycle %0d", e.ch, e.isRise, e.lo);
            end else begin
                o = obsQ.pop_front();
                if (o.ch != e.ch || o.isRise != e.isRise || o.dutB != e.dutB || o.lo < e.lo || o.lo > e.hi) begin
                    nFails++;
                    $display("FAIL latency_strobe: observed ch%0d rise=%0d dutB=%0d cycle %0d, expected ch%0d rise=%0d dutB=%0d cycle %0d",
                             o.ch, o.isRise, o.dutB, o.lo, e.ch, e.isRise, e.dutB, e.lo);
                end
            end
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL latency_extra: %0d unexpected strobes, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_boundary();
        int n;
        ev_t e, o;
        @(negedge clk);
        n = cyc;
        inA[2] = 1'b0;
        expQ.push_back('{n + 6, n + 6, 2, 1'b0, 1'b0});
        expQ.push_back('{n + 10, n + 10, 2, 1'b1, 1'b0});
        repeat (4) @(negedge clk);
        inA[2] = 1'b1;
        repeat (12) @(negedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (obsQ.size() == 0) begin
                nFails++;
                $display("FAIL boundary_strobe: observed none, expected ch%0d rise=%0d at cycle %0d", e.ch, e.isRise, e.lo);
            end else begin
                o = obsQ.pop_front();
                if (o.ch != e.ch || o.isRise != e.isRise || o.dutB != e.dutB || o.lo < e.lo || o.lo > e.hi) begin
                    nFails++;
                    $display("FAIL boundary_strobe: observed ch%0d rise=%0d dutB=%0d cycle %0d, expected ch%0d rise=%0d dutB=%0d cycle %0d",
                             o.ch, o.isRise, o.dutB, o.lo, e.ch, e.isRise, e.dutB, e.lo);
                end
            end
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL boundary_extra: %0d unexpected strobes, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_glitch();
        logic [7:0] expCnt;
        expCnt = GC_EN ? 8'd1 : 8'd0;
        @(negedge clk);
        inA[1] = 1'b0;
        repeat (3) @(negedge clk);
        inA[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nChecks++;
            if (outA[1] !== 1'b1) begin
                nFails++;
                $display("FAIL glitch_out: out[1]=%b, expected 1", outA[1]);
            end
        end
        nChecks++;
        if (glitchCountA !== {8'd0, expCnt, 8'd0}) begin
            nFails++;
            $display("FAIL glitch_count: glitchCount=%h, expected %h", glitchCountA, {8'd0, expCnt, 8'd0});
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL glitch_strobe: %0d strobes seen, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_saturate();
        logic [7:0] expSat, expCh1;
        expSat = GC_EN ? 8'd255 : 8'd0;
        expCh1 = GC_EN ? 8'd1 : 8'd0;
        for (int p = 0; p < 300; p++) begin
            @(negedge clk);
            inA[0] = 1'b0;
            @(negedge clk);
            inA[0] = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        nChecks++;
        if (glitchCountA !== {8'd0, expCh1, expSat}) begin
            nFails++;
            $display("FAIL saturate_count: glitchCount=%h, expected %h", glitchCountA, {8'd0, expCh1, expSat});
        end
        @(negedge clk);
        inA[0] = 1'b0;
        @(negedge clk);
        inA[0] = 1'b1;
        repeat (2) @(negedge clk);
        glitchClearA = 1'b1;
        @(negedge clk);
        glitchClearA = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++;
        if (glitchCountA !== 24'd0) begin
            nFails++;
            $display("FAIL clear_priority: glitchCount=%h, expected 000000", glitchCountA);
        end
        nChecks++;
        if (outA !== 3'b111 || obsQ.size() != 0) begin
            nFails++;
            $display("FAIL saturate_out: outA=%b strobes=%0d, expected 111 and 0", outA, obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_prescale();
        int n;
        ev_t e, o;
        for (int dir = 0; dir < 2; dir++) begin
            @(negedge clk);
            n = cyc;
            inB[2] = dir[0];
            expQ.push_back('{n + 84, n + 110, 2, dir[0], 1'b1});
            repeat (120) @(negedge clk);
            nChecks++;
            if (outB !== {dir[0], 2'b11}) begin
                nFails++;
                $display("FAIL prescale_out: outB=%b, expected %b", outB, {dir[0], 2'b11});
            end
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (obsQ.size() == 0) begin
                nFails++;
                $display("FAIL prescale_strobe: observed none, expected ch%0d rise=%0d in %0d..%0d", e.ch, e.isRise, e.lo, e.hi);
            end else begin
                o = obsQ.pop_front();
                if (o.ch != e.ch || o.isRise != e.isRise || o.dutB != e.dutB || o.lo < e.lo || o.lo > e.hi) begin
                    nFails++;
                    $display("FAIL prescale_strobe: observed ch%0d rise=%0d dutB=%0d cycle %0d, expected ch%0d rise=%0d dutB=%0d cycle %0d..%0d",
                             o.ch, o.isRise, o.dutB, o.lo, e.ch, e.isRise, e.dutB, e.lo, e.hi);
                end
            end
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL prescale_extra: %0d unexpected strobes, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        ev_t e, o;
        @(negedge clk);
        n = cyc;
        inA[1] = 1'b0;
        expQ.push_back('{n + 6, n + 6, 1, 1'b0, 1'b0});
        repeat (10) @(negedge clk);
        inA[1] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nChecks++;
        if (outA !== 3'b111 || riseA !== 3'b000 || fallA !== 3'b000) begin
            nFails++;
            $display("FAIL reset_mid_state: outA=%b riseA=%b fallA=%b, expected 111 000 000", outA, riseA, fallA);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n = cyc;
        inA[1] = 1'b0;
        expQ.push_back('{n + 6, n + 6, 1, 1'b0, 1'b0});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cyc == n + 5) begin
                nChecks++;
                if (outA[1] !== 1'b1) begin
                    nFails++;
                    $display("FAIL reset_mid_fresh: out[1]=%b at cycle +5, expected 1", outA[1]);
                end
            end
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (obsQ.size() == 0) begin
                nFails++;
                $display("FAIL reset_mid_strobe: observed none, expected ch%0d rise=%0d at cycle %0d", e.ch, e.isRise, e.lo);
            end else begin
                o = obsQ.pop_front();
                if (o.ch != e.ch || o.isRise != e.isRise || o.dutB != e.dutB || o.lo < e.lo || o.lo > e.hi) begin
                    nFails++;
                    $display("FAIL reset_mid_strobe: observed ch%0d rise=%0d dutB=%0d cycle %0d, expected ch%0d rise=%0d dutB=%0d cycle %0d",
                             o.ch, o.isRise, o.dutB, o.lo, e.ch, e.isRise, e.dutB, e.lo);
                end
            end
        end
        nChecks++;
        if (obsQ.size() != 0) begin
            nFails++;
            $display("FAIL reset_mid_extra: %0d unexpected strobes, expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundary();
        test_glitch();
        test_saturate();
        test_prescale();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
